// File: rtl/pixel_write_arbiter_pkg.sv
// pixel_write_arbiter_pkg: shared state encoding and job field layout.
//   Job word (JOB_W bits): {colour[2:0], h_m1[7:0], w_m1[7:0], y[7:0], x[7:0]}
package pixel_write_arbiter_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_DRAW = 1'b1} state_t;
    localparam int JOB_W = 35;
    localparam int X_LSB = 0;
    localparam int Y_LSB = 8;
    localparam int W_LSB = 16;
    localparam int H_LSB = 24;
    localparam int C_LSB = 32;
endpackage

// File: rtl/pixel_write_arbiter_rr_arbiter.sv
// pixel_write_arbiter_rr_arbiter: round-robin picker over N requesters.
//   i_clk, i_resetn : clock, async active-low reset (pointer -> 0)
//   i_req           : request vector
//   i_advance       : move pointer past the current pick
//   o_gnt / o_idx   : combinational one-hot pick and its index
module pixel_write_arbiter_rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 i_clk,
    input  logic                 i_resetn,
    input  logic [N-1:0]         i_req,
    input  logic                 i_advance,
    output logic [N-1:0]         o_gnt,
    output logic [$clog2(N)-1:0] o_idx
);
    localparam int PW = $clog2(N);
    logic [PW-1:0] r_ptr;
    logic          w_found;
    int            w_j;
    // Scan from the pointer upward, wrapping; first set bit wins.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < N; k++) begin
            w_j = int'(r_ptr) + k;
            w_j = (w_j >= N) ? w_j - N : w_j;
            if (!w_found && i_req[w_j[PW-1:0]]) begin
                w_found            = 1'b1;
                o_gnt[w_j[PW-1:0]] = 1'b1;
                o_idx              = w_j[PW-1:0];
            end
        end
    end
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn)
            r_ptr <= '0;
        else if (i_advance)
            r_ptr <= (int'(o_idx) == N - 1) ? '0 : o_idx + 1'b1;
    end
endmodule

// File: rtl/pixel_write_arbiter.sv
// pixel_write_arbiter: round-robin share of the VGA write port; rasterises
// the granted filled-rectangle job one pixel per clock with screen clipping.
//   i_clk, i_resetn   : clock, async active-low reset
//   i_req, i_job      : per-requester level request and packed job
//   o_gnt, o_done     : one-cycle one-hot grant / completion pulses
//   o_busy            : high from the grant cycle through the done cycle
//   o_vga_*           : pixel column/row/colour and write enable
module pixel_write_arbiter
    import pixel_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic                     i_clk,
    input  logic                     i_resetn,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ*JOB_W-1:0] i_job,
    output logic [NUM_REQ-1:0]       o_gnt,
    output logic [NUM_REQ-1:0]       o_done,
    output logic                     o_busy,
    output logic [7:0]               o_vga_x,
    output logic [7:0]               o_vga_y,
    output logic [2:0]               o_vga_colour,
    output logic                     o_vga_plot
);
    localparam int         PW    = $clog2(NUM_REQ);
    localparam logic [8:0] LIM_X = 9'(SCREEN_W);
    localparam logic [8:0] LIM_Y = 9'(SCREEN_H);
    state_t               r_state;
    logic [7:0]           r_x, r_y, r_w, r_h, r_col, r_row;
    logic [2:0]           r_colour;
    logic [NUM_REQ-1:0]   r_owner;
    logic [NUM_REQ-1:0]   w_gnt;
    logic [PW-1:0]        w_idx;
    logic [JOB_W-1:0]     w_sel;
    logic [8:0]           w_px, w_py;
    logic                 w_advance, w_last, w_eol;
    assign w_advance = (r_state == ST_IDLE) && |i_req;
    assign w_sel     = i_job[int'(w_idx)*JOB_W +: JOB_W];
    // 9-bit sums so off-screen pixels are detected rather than wrapped.
    assign w_px      = {1'b0, r_x} + {1'b0, r_col};
    assign w_py      = {1'b0, r_y} + {1'b0, r_row};
    assign w_eol     = r_col == r_w;
    assign w_last    = w_eol && (r_row == r_h);
    pixel_write_arbiter_rr_arbiter #(.N(NUM_REQ)) u_rr (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .i_req    (i_req),
        .i_advance(w_advance),
        .o_gnt    (w_gnt),
        .o_idx    (w_idx)
    );
    // DRAW with done already showing is the final cycle: it only returns
    // to IDLE, which yields the one-cycle bubble between jobs.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state      <= ST_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_w          <= '0;
            r_h          <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_colour     <= '0;
            r_owner      <= '0;
            o_gnt        <= '0;
            o_done       <= '0;
            o_busy       <= 1'b0;
            o_vga_x      <= '0;
            o_vga_y      <= '0;
            o_vga_colour <= '0;
            o_vga_plot   <= 1'b0;
        end else begin
            o_gnt      <= '0;
            o_done     <= '0;
            o_vga_plot <= 1'b0;
            if (r_state == ST_IDLE) begin
                o_busy <= w_advance;
                if (w_advance) begin
                    r_state  <= ST_DRAW;
                    o_gnt    <= w_gnt;
                    r_owner  <= w_gnt;
                    r_x      <= w_sel[X_LSB +: 8];
                    r_y      <= w_sel[Y_LSB +: 8];
                    r_w      <= w_sel[W_LSB +: 8];
                    r_h      <= w_sel[H_LSB +: 8];
                    r_colour <= w_sel[C_LSB +: 3];
                    r_col    <= '0;
                    r_row    <= '0;
                end
            end else if (|o_done) begin
                r_state <= ST_IDLE;
                o_busy  <= 1'b0;
            end else begin
                o_vga_x      <= w_px[7:0];
                o_vga_y      <= w_py[7:0];
                o_vga_colour <= r_colour;
                o_vga_plot   <= (w_px < LIM_X) && (w_py < LIM_Y);
                o_done       <= w_last ? r_owner : '0;
                r_col        <= w_eol ? 8'd0 : r_col + 8'd1;
                r_row        <= w_eol ? r_row + 8'd1 : r_row;
            end
        end
    end
endmodule
